// File: rtl/debounce_botao.sv
// Push-button debouncer: two-flop synchronizer followed by a 4-state
// qualification FSM. Every flop updates on the falling clock edge so that
// d is stable around the rising edge of the downstream D flip-flop.
// N_ESTAVEL must satisfy 2 <= N_ESTAVEL <= 2**LARG_CONT - 1.
module debounce_botao #(
   parameter int N_ESTAVEL = 4,
   parameter int LARG_CONT = 3
) (
   input  logic clk,
   input  logic clear,
   input  logic botao,
   output logic d,
   output logic pulso,
   output logic ocupado
);

   typedef enum logic [1:0] {
      ESTAVEL0,
      VALIDA1,
      ESTAVEL1,
      VALIDA0
   } estado_t;

   localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(N_ESTAVEL - 1);
   localparam logic [LARG_CONT-1:0] CONT_UM  = LARG_CONT'(1);

   logic                 s1_q, s2_q;
   estado_t              estado_q, estado_d;
   logic [LARG_CONT-1:0] cont_q, cont_d;
   logic                 d_q, d_d;
   logic                 pulso_q, pulso_d;
   logic                 ocupado_q, ocupado_d;

   // Two-flop synchronizer: the only place botao is read.
   always_ff @(negedge clk or negedge clear) begin
      if (!clear) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= botao;
         s2_q <= s1_q;
      end
   end

   // State, counter and registered outputs.
   always_ff @(negedge clk or negedge clear) begin
      if (!clear) begin
         estado_q  <= ESTAVEL0;
         cont_q    <= '0;
         d_q       <= 1'b0;
         pulso_q   <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cont_q    <= cont_d;
         d_q       <= d_d;
         pulso_q   <= pulso_d;
         ocupado_q <= ocupado_d;
      end
   end

   // Next-state logic: a candidate level must be seen N_ESTAVEL consecutive
   // times; any opposite sample drops back to the stable state with cont=0.
   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      d_d      = d_q;
      pulso_d  = 1'b0;
      unique case (estado_q)
         ESTAVEL0: begin
            if (s2_q) begin
               estado_d = VALIDA1;
               cont_d   = CONT_UM;
            end
         end
         VALIDA1: begin
            if (!s2_q) begin
               estado_d = ESTAVEL0;
               cont_d   = '0;
            end else if (cont_q == CONT_MAX) begin
               estado_d = ESTAVEL1;
               cont_d   = '0;
               d_d      = 1'b1;
               pulso_d  = 1'b1;
            end else begin
               cont_d = cont_q + CONT_UM;
            end
         end
         ESTAVEL1: begin
            if (!s2_q) begin
               estado_d = VALIDA0;
               cont_d   = CONT_UM;
            end
         end
         VALIDA0: begin
            if (s2_q) begin
               estado_d = ESTAVEL1;
               cont_d   = '0;
            end else if (cont_q == CONT_MAX) begin
               estado_d = ESTAVEL0;
               cont_d   = '0;
               d_d      = 1'b0;
            end else begin
               cont_d = cont_q + CONT_UM;
            end
         end
         default: begin
            estado_d = ESTAVEL0;
            cont_d   = '0;
         end
      endcase
      // ocupado is registered from the next state so it lines up with estado_q.
      ocupado_d = (estado_d == VALIDA1) || (estado_d == VALIDA0);
   end

   assign d       = d_q;
   assign pulso   = pulso_q;
   assign ocupado = ocupado_q;

endmodule

// File: tb/tb_debounce_botao.sv
// Testbench for debounce_botao (N_ESTAVEL=4): directed timing scenarios with
// fixed expectations plus randomized press/release traffic checked against a
// run-length reference model.
module tb_debounce_botao;

   localparam int N = 4;

   logic clk;
   logic clear;
   logic botao;
   logic d;
   logic pulso;
   logic ocupado;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: synchronizer pipeline plus the count of consecutive
   // synchronized samples that disagree with the accepted level.
   logic m_s1, m_s2, m_d, m_p, m_o;
   int   m_run;

   debounce_botao #(.N_ESTAVEL(N), .LARG_CONT(3)) dut (
      .clk    (clk),
      .clear  (clear),
      .botao  (botao),
      .d      (d),
      .pulso  (pulso),
      .ocupado(ocupado)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_d = 0; m_p = 0; m_o = 0; m_run = 0;
   endtask

   // Drive botao for one period, advance to the falling edge, update model,
   // then settle 1 ns so outputs are sampled away from the edge.
   task automatic step(input logic b);
      logic seen;
      botao = b;
      @(negedge clk);
      if (!clear) begin
         model_reset();
      end else begin
         seen = m_s2;
         m_s2 = m_s1;
         m_s1 = b;
         m_p  = 0;
         if (seen != m_d) begin
            m_run++;
            if (m_run == N) begin
               m_d   = ~m_d;
               m_p   = m_d;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_o = (m_run > 0);
      end
      #1;
   endtask

   task automatic settle_level(input logic b);
      for (int i = 0; i < 8; i++) step(b);
   endtask

   task automatic test_reset();
      clear = 1'b0;
      botao = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         n_checks++;
         if ({d, pulso, ocupado} !== 3'b000)
            $display("FAIL reset_hold: got d/pulso/ocupado=%b%b%b want 000", d, pulso, ocupado);
         else n_pass++;
      end
      botao = 1'b0;
      #2 clear = 1'b1;
      settle_level(1'b0);
      n_checks++;
      if ({d, pulso, ocupado} !== 3'b000)
         $display("FAIL reset_release: got %b%b%b want 000", d, pulso, ocupado);
      else n_pass++;
   endtask

   task automatic test_clean_press();
      logic ed, ep, eo;
      for (int i = 0; i <= 7; i++) begin
         step(1'b1);
         ed = (i >= 5);
         ep = (i == 5);
         eo = (i >= 2 && i <= 4);
         n_checks++;
         if ({d, pulso, ocupado} !== {ed, ep, eo})
            $display("FAIL clean_press E0+%0d: got d/pulso/ocupado=%b%b%b want %b%b%b",
                     i, d, pulso, ocupado, ed, ep, eo);
         else n_pass++;
      end
   endtask

   task automatic test_release();
      logic ed, eo;
      for (int i = 0; i <= 7; i++) begin
         step(1'b0);
         ed = (i < 5);
         eo = (i >= 2 && i <= 4);
         n_checks++;
         if ({d, pulso, ocupado} !== {ed, 1'b0, eo})
            $display("FAIL release E0+%0d: got d/pulso/ocupado=%b%b%b want %b0%b",
                     i, d, pulso, ocupado, ed, eo);
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      logic eo;
      for (int i = 0; i <= 8; i++) begin
         step(i < 2 ? 1'b1 : 1'b0);
         eo = (i == 2 || i == 3);
         n_checks++;
         if ({d, pulso, ocupado} !== {1'b0, 1'b0, eo})
            $display("FAIL glitch E0+%0d: got d/pulso/ocupado=%b%b%b want 00%b",
                     i, d, pulso, ocupado, eo);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      int pulses;
      pat = 5'b10101;  // bit i is the sample driven at index i
      pulses = 0;
      for (int i = 0; i <= 14; i++) begin
         step(i < 5 ? pat[i] : 1'b1);
         if (pulso === 1'b1) pulses++;
         n_checks++;
         if (d !== (i >= 9))
            $display("FAIL bounce_d idx%0d: got d=%b want %b", i, d, (i >= 9));
         else n_pass++;
      end
      n_checks++;
      if (pulses !== 1)
         $display("FAIL bounce_pulses: got %0d want 1", pulses);
      else n_pass++;
   endtask

   task automatic test_reset_mid_validation();
      logic ed, ep;
      for (int i = 0; i <= 3; i++) step(1'b1);  // edge 3 leaves VALIDA1 with cont=2
      n_checks++;
      if (ocupado !== 1'b1)
         $display("FAIL midval_busy: got ocupado=%b want 1", ocupado);
      else n_pass++;
      #2 clear = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({d, pulso, ocupado} !== 3'b000)
         $display("FAIL midval_async_clear: got %b%b%b want 000", d, pulso, ocupado);
      else n_pass++;
      step(1'b1);
      step(1'b1);
      #2 clear = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         step(1'b1);
         ed = (i >= 5);
         ep = (i == 5);
         n_checks++;
         if ({d, pulso} !== {ed, ep})
            $display("FAIL midval_requal E0+%0d: got d/pulso=%b%b want %b%b", i, d, pulso, ed, ep);
         else n_pass++;
      end
   endtask

   task automatic test_random_cycles();
      int pulses, width, maxw;
      for (int c = 0; c < 10; c++) begin
         for (int ph = 0; ph < 2; ph++) begin
            logic lvl;
            lvl = (ph == 0);
            pulses = 0; width = 0; maxw = 0;
            for (int b = 0; b < int'($urandom_range(0, 6)); b++)
               step(1'($urandom));
            for (int i = 0; i < 12; i++) begin
               step(lvl);
               if (pulso === 1'b1) begin pulses++; width++; end else width = 0;
               if (width > maxw) maxw = width;
               n_checks++;
               if ({d, pulso, ocupado} !== {m_d, m_p, m_o})
                  $display("FAIL random_model c%0d ph%0d: got %b%b%b want %b%b%b",
                           c, ph, d, pulso, ocupado, m_d, m_p, m_o);
               else n_pass++;
            end
            n_checks++;
            if (d !== lvl || pulses !== (ph == 0 ? 1 : 0) || maxw > 1)
               $display("FAIL random_cycle c%0d ph%0d: got d=%b pulses=%0d width=%0d want d=%b pulses=%0d width<=1",
                        c, ph, d, pulses, maxw, lvl, (ph == 0 ? 1 : 0));
            else n_pass++;
         end
      end
   endtask

   initial begin
      clear = 1'b0;
      botao = 1'b0;
      model_reset();
      test_reset();
      test_clean_press();
      test_release();
      settle_level(1'b0);
      test_glitch();
      settle_level(1'b0);
      test_bounce();
      settle_level(1'b1);
      settle_level(1'b0);
      test_reset_mid_validation();
      settle_level(1'b0);
      test_random_cycles();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
